// File: rtl/sd_cmd_sequencer.sv
// Card-side SD SPI-mode command sequencer: init FSM, CMD16 block length and R1/R7 response stream.
// Define SD_CMD_SEQ_CMD58_EN to answer CMD58 with an R3/OCR response instead of flagging it illegal.
module sd_cmd_sequencer #(
  parameter int          INIT_POLLS    = 2,
  parameter int          MAX_BLOCK_LEN = 512,
  parameter logic [31:0] OCR_VALUE     = 32'h00FF8000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_index,
  input  logic [31:0] cmd_arg,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [7:0]  resp_data,
  output logic        resp_last,
  output logic [1:0]  card_state,
  output logic [9:0]  block_len,
  output logic        app_pending
);

  typedef enum logic [1:0] {POWERUP = 2'd0, IDLE = 2'd1, READY = 2'd2} card_t;
  typedef enum logic {PH_WAIT, PH_SEND} phase_t;

  localparam logic [3:0]  LAST_POLL = 4'(INIT_POLLS - 1);
  localparam logic [9:0]  BLEN_RST  = 10'(MAX_BLOCK_LEN);
  localparam logic [31:0] BLEN_MAX  = 32'(MAX_BLOCK_LEN);

  phase_t      phase, phase_nxt;
  card_t       card, card_nxt;
  logic [39:0] shift_q, shift_nxt;
  logic [2:0]  left_q, left_nxt;
  logic [9:0]  blen_nxt;
  logic        app_nxt;
  logic [3:0]  poll_q, poll_nxt;
  logic        accept, idle_bit, respond;
  logic [7:0]  r1;
  logic [31:0] tail;
  logic [2:0]  nbytes;

  always_ff @(posedge clock) begin
    if (!reset) begin
      phase       <= PH_WAIT;
      card        <= POWERUP;
      shift_q     <= '0;
      left_q      <= '0;
      block_len   <= BLEN_RST;
      app_pending <= 1'b0;
      poll_q      <= '0;
    end else begin
      phase       <= phase_nxt;
      card        <= card_nxt;
      shift_q     <= shift_nxt;
      left_q      <= left_nxt;
      block_len   <= blen_nxt;
      app_pending <= app_nxt;
      poll_q      <= poll_nxt;
    end
  end

  always_comb begin
    phase_nxt = phase;
    card_nxt  = card;
    shift_nxt = shift_q;
    left_nxt  = left_q;
    blen_nxt  = block_len;
    app_nxt   = app_pending;
    poll_nxt  = poll_q;
    idle_bit  = (card != READY);
    r1        = {7'd0, idle_bit};
    tail      = '0;
    nbytes    = 3'd1;
    respond   = 1'b0;
    accept    = cmd_valid && (phase == PH_WAIT);

    if (phase == PH_SEND) begin
      if (resp_ready) begin
        if (left_q == 3'd1) begin
          phase_nxt = PH_WAIT;
        end else begin
          shift_nxt = {shift_q[31:0], 8'h00};
          left_nxt  = left_q - 3'd1;
        end
      end
    end else if (accept) begin
      if (cmd_index == 6'd0) begin
        card_nxt = IDLE;
        poll_nxt = '0;
        blen_nxt = BLEN_RST;
        app_nxt  = 1'b0;
        r1       = 8'h01;
        respond  = 1'b1;
      end else if (card != POWERUP) begin
        // Before CMD0 the card is deaf: everything else is ignored without touching state.
        respond = 1'b1;
        app_nxt = 1'b0;
        case (cmd_index)
          6'd8: begin
            nbytes = 3'd5;
            tail   = {20'h0, cmd_arg[11:0]};
          end
          6'd55: app_nxt = 1'b1;
          6'd41: begin
            if (!app_pending) begin
              r1[2] = 1'b1;
            end else if (card != READY && poll_q < LAST_POLL) begin
              poll_nxt = poll_q + 4'd1;
            end else begin
              card_nxt = READY;
              r1       = 8'h00;
            end
          end
          6'd16: begin
            if (cmd_arg != 32'd0 && cmd_arg <= BLEN_MAX) blen_nxt = cmd_arg[9:0];
            else r1[6] = 1'b1;
          end
`ifdef SD_CMD_SEQ_CMD58_EN
          6'd58: begin
            nbytes = 3'd5;
            tail   = {~idle_bit, 1'b0, OCR_VALUE[29:0]};
          end
`endif
          default: r1[2] = 1'b1;
        endcase
      end
      if (respond) begin
        phase_nxt = PH_SEND;
        shift_nxt = {r1, tail};
        left_nxt  = nbytes;
      end
    end
  end

  assign cmd_ready  = (phase == PH_WAIT);
  assign resp_valid = (phase == PH_SEND);
  assign resp_data  = resp_valid ? shift_q[39:32] : 8'h00;
  assign resp_last  = resp_valid && (left_q == 3'd1);
  assign card_state = card;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed testbench for sd_cmd_sequencer: init sequence, R1/R7 bytes, CMD16, backpressure and reset.
// Honours SD_CMD_SEQ_CMD58_EN for the CMD58 expectation.
module tb_sd_cmd_sequencer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        resp_valid;
  logic        resp_ready;
  logic [7:0]  resp_data;
  logic        resp_last;
  logic [1:0]  card_state;
  logic [9:0]  block_len;
  logic        app_pending;

  int checkCount = 0;
  int errorCount = 0;

  sd_cmd_sequencer dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_last(resp_last),
    .card_state(card_state), .block_len(block_len), .app_pending(app_pending)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [39:0] actual, input logic [39:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One-cycle command pulse; returns at the negedge right after the accepting edge.
  task automatic applyStimulus(input logic [5:0] idx, input logic [31:0] arg);
    @(negedge clock);
    cmd_valid = 1'b1;
    cmd_index = idx;
    cmd_arg   = arg;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  // Expects n bytes (first byte in bits 39:32) on consecutive cycles with resp_ready held high.
  task automatic expectResp(input string tag, input int n, input logic [39:0] bytes);
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, " valid"}, 40'(resp_valid), 40'd1);
      checkOutput({tag, " data"}, 40'(resp_data), 40'(bytes[39-8*i -: 8]));
      checkOutput({tag, " last"}, 40'(resp_last), 40'(i == n - 1));
      @(negedge clock);
    end
    checkOutput({tag, " done valid"}, 40'(resp_valid), 40'd0);
    checkOutput({tag, " done ready"}, 40'(cmd_ready), 40'd1);
  endtask

  initial begin
    reset      = 1'b0;
    cmd_valid  = 1'b0;
    cmd_index  = '0;
    cmd_arg    = '0;
    resp_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst card_state", 40'(card_state), 40'd0);
    checkOutput("rst cmd_ready", 40'(cmd_ready), 40'd1);
    checkOutput("rst resp_valid", 40'(resp_valid), 40'd0);
    checkOutput("rst resp_data", 40'(resp_data), 40'd0);
    checkOutput("rst resp_last", 40'(resp_last), 40'd0);
    checkOutput("rst block_len", 40'(block_len), 40'd512);
    checkOutput("rst app_pending", 40'(app_pending), 40'd0);
    reset = 1'b1;

    // POWERUP ignores CMD8, CMD0 enters IDLE
    applyStimulus(6'd8, 32'h1AA);
    checkOutput("pwr cmd8 valid", 40'(resp_valid), 40'd0);
    checkOutput("pwr cmd8 ready", 40'(cmd_ready), 40'd1);
    checkOutput("pwr cmd8 state", 40'(card_state), 40'd0);
    applyStimulus(6'd0, 32'h0);
    expectResp("cmd0", 1, 40'h01_0000_0000);
    checkOutput("cmd0 state", 40'(card_state), 40'd1);

    // R7 echo
    applyStimulus(6'd0, 32'h0);
    expectResp("cmd0b", 1, 40'h01_0000_0000);
    applyStimulus(6'd8, 32'h0000_01AA);
    expectResp("r7 idle", 5, 40'h01_0000_01AA);

    // Init polling, INIT_POLLS=2
    applyStimulus(6'd55, 32'h0);
    expectResp("cmd55 a", 1, 40'h01_0000_0000);
    checkOutput("app set", 40'(app_pending), 40'd1);
    applyStimulus(6'd41, 32'h0);
    expectResp("acmd41 a", 1, 40'h01_0000_0000);
    checkOutput("app clr", 40'(app_pending), 40'd0);
    checkOutput("poll1 state", 40'(card_state), 40'd1);
    applyStimulus(6'd55, 32'h0);
    expectResp("cmd55 b", 1, 40'h01_0000_0000);
    applyStimulus(6'd41, 32'h0);
    expectResp("acmd41 b", 1, 40'h00_0000_0000);
    checkOutput("ready state", 40'(card_state), 40'd2);

    // Back to IDLE: double CMD55, CMD16 range checks, bare CMD41
    applyStimulus(6'd0, 32'h0);
    expectResp("cmd0c", 1, 40'h01_0000_0000);
    checkOutput("cmd0c state", 40'(card_state), 40'd1);
    applyStimulus(6'd55, 32'h0);
    expectResp("cmd55 c", 1, 40'h01_0000_0000);
    applyStimulus(6'd55, 32'h0);
    expectResp("cmd55 d", 1, 40'h01_0000_0000);
    checkOutput("app kept", 40'(app_pending), 40'd1);
    applyStimulus(6'd16, 32'd512);
    expectResp("cmd16 512", 1, 40'h01_0000_0000);
    checkOutput("blen 512", 40'(block_len), 40'd512);
    checkOutput("app clr16", 40'(app_pending), 40'd0);
    applyStimulus(6'd16, 32'd8);
    expectResp("cmd16 8", 1, 40'h01_0000_0000);
    checkOutput("blen 8", 40'(block_len), 40'd8);
    applyStimulus(6'd16, 32'd0);
    expectResp("cmd16 0", 1, 40'h41_0000_0000);
    checkOutput("blen keep0", 40'(block_len), 40'd8);
    applyStimulus(6'd16, 32'd513);
    expectResp("cmd16 513", 1, 40'h41_0000_0000);
    checkOutput("blen keep513", 40'(block_len), 40'd8);
    applyStimulus(6'd41, 32'h0);
    expectResp("cmd41 bare", 1, 40'h05_0000_0000);
    checkOutput("bare41 state", 40'(card_state), 40'd1);

    // Reach READY again (counter cleared by CMD0) and check READY responses
    for (int k = 0; k < 2; k++) begin
      applyStimulus(6'd55, 32'h0);
      expectResp("cmd55 r", 1, 40'h01_0000_0000);
      applyStimulus(6'd41, 32'h0);
      expectResp("acmd41 r", 1, (k == 0) ? 40'h01_0000_0000 : 40'h00_0000_0000);
    end
    checkOutput("ready2 state", 40'(card_state), 40'd2);
    applyStimulus(6'd17, 32'h0);
    expectResp("illegal ready", 1, 40'h04_0000_0000);
    applyStimulus(6'd16, 32'd2000);
    expectResp("cmd16 ready bad", 1, 40'h40_0000_0000);
    applyStimulus(6'd16, 32'd64);
    expectResp("cmd16 64", 1, 40'h00_0000_0000);
    checkOutput("blen 64", 40'(block_len), 40'd64);
    applyStimulus(6'd8, 32'h0000_0A5C);
    expectResp("r7 ready", 5, 40'h00_0000_0A5C);
`ifdef SD_CMD_SEQ_CMD58_EN
    applyStimulus(6'd58, 32'h0);
    expectResp("cmd58", 5, 40'h00_80FF_8000);
`else
    applyStimulus(6'd58, 32'h0);
    expectResp("cmd58", 1, 40'h04_0000_0000);
`endif

    // Backpressure: byte 0 held, CMD0 dropped while busy
    resp_ready = 1'b0;
    applyStimulus(6'd8, 32'h0000_01AA);
    for (int k = 0; k < 10; k++) begin
      checkOutput("hold valid", 40'(resp_valid), 40'd1);
      checkOutput("hold data", 40'(resp_data), 40'h00);
      checkOutput("hold ready", 40'(cmd_ready), 40'd0);
      cmd_valid = 1'b1;
      cmd_index = 6'd0;
      @(negedge clock);
    end
    cmd_valid  = 1'b0;
    resp_ready = 1'b1;
    expectResp("r7 held", 5, 40'h00_0000_01AA);
    checkOutput("drop state", 40'(card_state), 40'd2);
    checkOutput("drop blen", 40'(block_len), 40'd64);

    // Reset mid-response after byte 2 is taken
    applyStimulus(6'd8, 32'h0000_01AA);
    repeat (3) @(negedge clock);
    checkOutput("mid byte3", 40'(resp_data), 40'h01);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("midrst valid", 40'(resp_valid), 40'd0);
    checkOutput("midrst state", 40'(card_state), 40'd0);
    checkOutput("midrst blen", 40'(block_len), 40'd512);
    checkOutput("midrst ready", 40'(cmd_ready), 40'd1);
    reset = 1'b1;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
